// File: rtl/core_pkg.sv
// Shared constants and types for the RV32 front-end pipeline.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // Bubble encoding; downstream hazard logic treats all-zero as a no-op.
  localparam logic [XLEN-1:0] NOP_IR = 32'h0000_0000;

  // Interlock phase; 2'b11 is unreachable and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HOLD1 = 2'b01,
    HOLD2 = 2'b10
  } stall_state_t;

endpackage

// File: rtl/fetch_pipe_ctrl_stall_seq.sv
// Interlock phase counter: every load-use interlock spans exactly two bubble cycles.
module stall_seq
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       flush,
  output logic [1:0] stall_counter
);

  stall_state_t state_q, state_d;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a redirect aborts any interlock in progress.
  always_comb begin
    state_d = IDLE;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = stall ? HOLD1 : IDLE;
        HOLD1:   state_d = HOLD2;
        // A fresh hazard here cannot really occur (bubble in ID/EX) but is handled anyway.
        HOLD2:   state_d = stall ? HOLD1 : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output: the counter is the registered state itself.
  always_comb begin
    stall_counter = state_q;
  end

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// Front-end pipeline control: PC, IF/ID register and the instruction half of ID/EX.
module fetch_pipe_ctrl
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_IR   = core_pkg::NOP_IR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] if_id_ir,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] id_ex_ir,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [1:0]      stall_counter
);

  // Pipeline registers; redirect has priority over interlock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      if_id_ir <= NOP_IR;
      if_id_pc <= '0;
      id_ex_ir <= NOP_IR;
      id_ex_pc <= '0;
    end else if (branch_taken) begin
      // Low bits dropped silently; misalignment is not trapped here.
      pc       <= {branch_target[XLEN-1:2], 2'b00};
      if_id_ir <= NOP_IR;
      if_id_pc <= '0;
      id_ex_ir <= NOP_IR;
      id_ex_pc <= '0;
    end else if (stall) begin
      // Hold fetch and IF/ID, inject a bubble into ID/EX.
      id_ex_ir <= NOP_IR;
      id_ex_pc <= '0;
    end else begin
      pc       <= pc + PC_STEP;
      if_id_ir <= imem_rdata;
      if_id_pc <= pc;
      id_ex_ir <= if_id_ir;
      id_ex_pc <= if_id_pc;
    end
  end

  stall_seq u_stall_seq (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (branch_taken),
    .stall_counter (stall_counter)
  );

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Directed self-checking bench for fetch_pipe_ctrl.
module tb_fetch_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] imem_rdata;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] pc, if_id_ir, if_id_pc, id_ex_ir, id_ex_pc;
  logic [1:0]  stall_counter;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I0 = 32'h0010_0093;
  localparam logic [31:0] I1 = 32'h0020_8113;

  always #5 clk = ~clk;

  // Instruction memory: two real instructions, elsewhere a tagged address.
  always_comb begin
    if (pc == 32'h0)      imem_rdata = I0;
    else if (pc == 32'h4) imem_rdata = I1;
    else                  imem_rdata = 32'hA000_0000 | pc;
  end

  fetch_pipe_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .if_id_ir      (if_id_ir),
    .if_id_pc      (if_id_pc),
    .id_ex_ir      (id_ex_ir),
    .id_ex_pc      (id_ex_pc),
    .stall_counter (stall_counter)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    checks++; if (if_id_ir !== 32'h0) begin errors++; $display("FAIL reset_if_id_ir got %h want 0", if_id_ir); end
    checks++; if (id_ex_ir !== 32'h0) begin errors++; $display("FAIL reset_id_ex_ir got %h want 0", id_ex_ir); end
    checks++; if (if_id_pc !== 32'h0 || id_ex_pc !== 32'h0) begin errors++; $display("FAIL reset_pcs got %h/%h want 0/0", if_id_pc, id_ex_pc); end
    checks++; if (stall_counter !== 2'b00) begin errors++; $display("FAIL reset_cnt got %b want 00", stall_counter); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_straight_line();
    step();
    checks++; if (if_id_ir !== I0) begin errors++; $display("FAIL sl1_if_id_ir got %h want %h", if_id_ir, I0); end
    checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL sl1_if_id_pc got %h want 0", if_id_pc); end
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL sl1_pc got %h want 4", pc); end
    step();
    checks++; if (id_ex_ir !== I0) begin errors++; $display("FAIL sl2_id_ex_ir got %h want %h", id_ex_ir, I0); end
    checks++; if (if_id_ir !== I1) begin errors++; $display("FAIL sl2_if_id_ir got %h want %h", if_id_ir, I1); end
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL sl2_pc got %h want 8", pc); end
  endtask

  // Entry: pc=8, if_id_ir=I1 (pc 4).
  task automatic test_load_use();
    stall = 1'b1;
    step();
    checks++; if (stall_counter !== 2'b01) begin errors++; $display("FAIL lu1_cnt got %b want 01", stall_counter); end
    checks++; if (id_ex_ir !== 32'h0 || id_ex_pc !== 32'h0) begin errors++; $display("FAIL lu1_bubble got %h/%h want 0/0", id_ex_ir, id_ex_pc); end
    checks++; if (pc !== 32'h8 || if_id_ir !== I1) begin errors++; $display("FAIL lu1_hold got pc %h ir %h want 8 %h", pc, if_id_ir, I1); end
    stall = 1'b1; // stall unit forces stall in HOLD1
    step();
    checks++; if (stall_counter !== 2'b10) begin errors++; $display("FAIL lu2_cnt got %b want 10", stall_counter); end
    checks++; if (id_ex_ir !== 32'h0) begin errors++; $display("FAIL lu2_bubble got %h want 0", id_ex_ir); end
    checks++; if (pc !== 32'h8 || if_id_ir !== I1 || if_id_pc !== 32'h4) begin errors++; $display("FAIL lu2_hold got pc %h ir %h ipc %h want 8 %h 4", pc, if_id_ir, if_id_pc, I1); end
    stall = 1'b0;
    step();
    checks++; if (stall_counter !== 2'b00) begin errors++; $display("FAIL lu3_cnt got %b want 00", stall_counter); end
    checks++; if (id_ex_ir !== I1 || id_ex_pc !== 32'h4) begin errors++; $display("FAIL lu3_id_ex got %h/%h want %h/4", id_ex_ir, id_ex_pc, I1); end
    checks++; if (pc !== 32'hC || if_id_ir !== 32'hA000_0008) begin errors++; $display("FAIL lu3_fetch got pc %h ir %h want c a0000008", pc, if_id_ir); end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1;
    branch_target = 32'h0000_0103;
    step();
    branch_taken = 1'b0;
    checks++; if (pc !== 32'h0000_0100) begin errors++; $display("FAIL br_pc got %h want 100", pc); end
    checks++; if (if_id_ir !== 32'h0 || id_ex_ir !== 32'h0) begin errors++; $display("FAIL br_flush got %h/%h want 0/0", if_id_ir, id_ex_ir); end
    checks++; if (if_id_pc !== 32'h0 || id_ex_pc !== 32'h0) begin errors++; $display("FAIL br_pcs got %h/%h want 0/0", if_id_pc, id_ex_pc); end
    step();
    checks++; if (if_id_ir !== 32'hA000_0100 || if_id_pc !== 32'h100 || pc !== 32'h104) begin errors++; $display("FAIL br_next got ir %h ipc %h pc %h want a0000100 100 104", if_id_ir, if_id_pc, pc); end
  endtask

  task automatic test_branch_in_hold();
    stall = 1'b1;
    step();
    checks++; if (stall_counter !== 2'b01) begin errors++; $display("FAIL bh_cnt1 got %b want 01", stall_counter); end
    branch_taken = 1'b1;
    branch_target = 32'h0000_0200;
    step();
    branch_taken = 1'b0;
    stall = 1'b0;
    checks++; if (stall_counter !== 2'b00) begin errors++; $display("FAIL bh_cnt2 got %b want 00", stall_counter); end
    checks++; if (pc !== 32'h200 || if_id_ir !== 32'h0 || id_ex_ir !== 32'h0) begin errors++; $display("FAIL bh_redirect got pc %h %h/%h want 200 0/0", pc, if_id_ir, id_ex_ir); end
  endtask

  task automatic test_hold2_restall();
    stall = 1'b1;
    step();
    step();
    checks++; if (stall_counter !== 2'b10) begin errors++; $display("FAIL h2_cnt got %b want 10", stall_counter); end
    step();
    checks++; if (stall_counter !== 2'b01) begin errors++; $display("FAIL h2_restall got %b want 01", stall_counter); end
    step();
    stall = 1'b0;
    step();
    checks++; if (stall_counter !== 2'b00 || pc !== 32'h204) begin errors++; $display("FAIL h2_exit got cnt %b pc %h want 00 204", stall_counter, pc); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    step();
    branch_taken = 1'b0;
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_pc0 got %h want fffffffc", pc); end
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wr_pc got %h want 0", pc); end
    checks++; if (if_id_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_if_id_pc got %h want fffffffc", if_id_pc); end
  endtask

  task automatic test_reset_mid();
    step();
    step();
    stall = 1'b1;
    step();
    #2 rst = 1'b1;
    #1;
    checks++; if (pc !== 32'h0 || if_id_ir !== 32'h0 || id_ex_ir !== 32'h0 || stall_counter !== 2'b00) begin
      errors++; $display("FAIL mid_reset got pc %h %h/%h cnt %b want 0 0/0 00", pc, if_id_ir, id_ex_ir, stall_counter);
    end
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    step();
    checks++; if (pc !== 32'h4 || if_id_pc !== 32'h0 || if_id_ir !== I0) begin errors++; $display("FAIL mid_refetch got pc %h ipc %h ir %h want 4 0 %h", pc, if_id_pc, if_id_ir, I0); end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_load_use();
    test_branch();
    test_branch_in_hold();
    test_hold2_restall();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
